bank_timing_fsm_array: RTL
==========================

Name: bank_timing_fsm_array

Overview:
- Parametrised next-generation per-bank DRAM timing state machine for the memory emulator.
- One timing FSM per bank, across BANKGROUPS x BANKSPERGROUP banks.
- Decodes one DRAM command per cycle and exposes every bank's state code to the emulator datapath.
- Beyond the earlier single-timing model it adds:
  - configurable timing and burst parameters;
  - tRAS enforcement;
  - precharge-all;
  - an illegal-command error flag;
  - a per-bank busy vector.

Parameters:
- BGWIDTH, 2, bank-group address width; 0 for DDR3, giving 1 group.
- BAWIDTH, 2, bank address width within a group.
- BL, 8, burst length; even, at least 2.
- T_CL, 17, read latency in clocks.
- T_RCD, 17, ACT-to-column delay in clocks.
- T_WR, 14, write recovery in clocks.
- T_RP, 17, precharge time in clocks.
- T_RAS, 39, minimum ACT-to-PR time in clocks.
- T_RFC, 34, refresh cycle time in clocks.
- NBANKS, derived as 2**(BGWIDTH+BAWIDTH); not overridable.
- CW, derived: counter width = clog2 of the largest of (T_CL+BL/2+T_WR, T_RCD, T_RP, T_RAS, T_RFC) + 1.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- bg, input, max(BGWIDTH,1), bank group of the current command; ignored when BGWIDTH=0.
- ba, input, BAWIDTH, bank of the current command.
- ACT, PR, PRA, RD, RDA, WR, WRA, REF, input, 1 each, command strobes; at most one high per cycle.
- BankFSM, output, 5*NBANKS, state code of each bank. Bank index = {bg,ba}; bank n occupies bits [5n+4:5n].
- busy, output, NBANKS, 1 when a bank is in any timed state (not idle and not active).
- cmd_err, output, 1, single-cycle pulse flagging a rejected command.

Behaviour:
- State codes:
  - IDLE 5'h00
  - ACTIVATING 5'h01
  - ACTIVE 5'h03
  - PRECHARGING 5'h0a
  - READING 5'h0b
  - READING_AP 5'h0c
  - REFRESHING 5'h0d
  - WRITING 5'h12
  - WRITING_AP 5'h13
- Reset, asserted asynchronously:
  - all banks go to IDLE;
  - all counters and tRAS counters clear;
  - busy=0, cmd_err=0.
  - Reset mid-operation aborts every timed state immediately.
- Commands are sampled on the rising edge. The new state is visible right after that edge; there is no extra pipeline stage.
- Timed states:
  - On entry, the bank counter loads D-1 for a state lasting D cycles, then decrements each clock.
  - On the edge where the counter equals 0, the bank leaves the state.
  - So the state is visible for exactly D cycles after the command edge.
- Durations and exits:
  - ACTIVATING: T_RCD cycles, then ACTIVE.
  - READING: T_CL+BL/2 cycles, then ACTIVE.
  - WRITING: T_CL+BL/2+T_WR cycles, then ACTIVE.
  - READING_AP: T_CL+BL/2 cycles, then PRECHARGING.
  - WRITING_AP: T_CL+BL/2+T_WR cycles, then PRECHARGING.
  - PRECHARGING: T_RP cycles, then IDLE.
  - REFRESHING: T_RFC cycles, then IDLE.
- tRAS counter (per bank):
  - loads T_RAS-1 on ACT and saturates at 0;
  - runs through ACTIVATING, ACTIVE, READING and WRITING.
- Legal transitions (addressed bank only):
  - ACT: IDLE -> ACTIVATING.
  - RD / WR: ACTIVE, READING or WRITING -> READING / WRITING, counter reloaded (back-to-back column commands restart timing).
  - RDA / WRA: ACTIVE, READING or WRITING -> READING_AP / WRITING_AP.
  - PR: ACTIVE, READING or WRITING -> PRECHARGING, only if the tRAS counter is 0.
  - PR to an IDLE bank is a legal no-op.
- PRA: every bank in ACTIVE, READING or WRITING with its tRAS counter at 0 enters PRECHARGING. Other banks are unaffected.
  - cmd_err pulses if any such open bank still has tRAS pending; that bank keeps its state.
- REF (all-bank): accepted only if every bank is IDLE; all banks then enter REFRESHING.
- Rejection: cmd_err pulses for one cycle on the edge after a rejected command, and the state is unchanged. A command is rejected when it is:
  - issued in an illegal state (e.g. ACT to a non-idle bank, RD to an IDLE bank, any command to a busy AP, PRECHARGING or REFRESHING bank);
  - a PR with tRAS not yet elapsed;
  - REF with any bank non-idle;
  - two or more strobes high in the same cycle.
- Non-addressed banks keep advancing their own timers on every cycle, including cycles with rejected commands.
- busy is combinational from the registered state. cmd_err is registered.

Test Plan:
- Reset released, ACT bg=1 ba=1 -> bank 5 = 5'h01 for 17 cycles, then 5'h03; all other banks stay 5'h00; busy[5] high for 17 cycles.
- Activate bank 5, wait 17 cycles, WR -> 5'h12 for 35 cycles, then 5'h03. RD during WRITING -> 5'h0b for 21 cycles, then 5'h03.
- ACT bank 5, PR 20 cycles later -> cmd_err one pulse, state remains active. PR at cycle 39 -> 5'h0a for 17 cycles, then 5'h00.
- Activate banks 0 and 5, wait 40 cycles, RDA to bank 0, then PRA the following cycle:
  - bank 5 -> 5'h0a for 17 cycles;
  - bank 0 follows 5'h0c (21 cycles) -> 5'h0a (17 cycles) -> 5'h00.
- REF with all banks idle -> all banks 5'h0d for 34 cycles, then 5'h00. REF with bank 3 active -> cmd_err, no state change.
- ACT and RD high together -> cmd_err, nothing changes.
- reset_n low mid-WRITING_AP -> all banks 5'h00 immediately; next ACT behaves normally.
- Repeat the first scenario with BGWIDTH=0 -> same behaviour.

Source files
------------

// File: rtl/bank_timing_fsm_array.sv
// Per-bank DRAM timing state machines for the memory emulator.
// One FSM per bank (2**(BGWIDTH+BAWIDTH) banks); one command decoded per cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   bg, ba              bank group / bank of the current command (bg ignored when BGWIDTH=0)
//   ACT..REF            command strobes, at most one high per cycle
//   BankFSM             5-bit state code per bank, bank n at [5n+4:5n]
//   busy                per-bank flag, high in any timed state
//   cmd_err             one-cycle pulse after a rejected command
module bank_timing_fsm_array #(
  parameter int unsigned BGWIDTH = 2,
  parameter int unsigned BAWIDTH = 2,
  parameter int unsigned BL      = 8,
  parameter int unsigned T_CL    = 17,
  parameter int unsigned T_RCD   = 17,
  parameter int unsigned T_WR    = 14,
  parameter int unsigned T_RP    = 17,
  parameter int unsigned T_RAS   = 39,
  parameter int unsigned T_RFC   = 34
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]  bg,
  input  logic [BAWIDTH-1:0]                        ba,
  input  logic                                      ACT,
  input  logic                                      PR,
  input  logic                                      PRA,
  input  logic                                      RD,
  input  logic                                      RDA,
  input  logic                                      WR,
  input  logic                                      WRA,
  input  logic                                      REF,
  output logic [5*(2**(BGWIDTH+BAWIDTH))-1:0]       BankFSM,
  output logic [(2**(BGWIDTH+BAWIDTH))-1:0]         busy,
  output logic                                      cmd_err
);

  localparam int unsigned AW     = BGWIDTH + BAWIDTH;
  localparam int unsigned NBANKS = 2 ** AW;
  localparam int unsigned D_RD   = T_CL + BL / 2;
  localparam int unsigned D_WR   = D_RD + T_WR;
  localparam int unsigned M1     = (D_WR > T_RCD) ? D_WR : T_RCD;
  localparam int unsigned M2     = (M1 > T_RP) ? M1 : T_RP;
  localparam int unsigned M3     = (M2 > T_RAS) ? M2 : T_RAS;
  localparam int unsigned MAXD   = (M3 > T_RFC) ? M3 : T_RFC;
  localparam int unsigned CW     = $clog2(MAXD) + 1;

  localparam logic [7:0] C_ACT = 8'h80;
  localparam logic [7:0] C_PR  = 8'h40;
  localparam logic [7:0] C_PRA = 8'h20;
  localparam logic [7:0] C_RD  = 8'h10;
  localparam logic [7:0] C_RDA = 8'h08;
  localparam logic [7:0] C_WR  = 8'h04;
  localparam logic [7:0] C_WRA = 8'h02;
  localparam logic [7:0] C_REF = 8'h01;

  typedef enum logic [4:0] {
    S_IDLE        = 5'h00,
    S_ACTIVATING  = 5'h01,
    S_ACTIVE      = 5'h03,
    S_PRECHARGING = 5'h0a,
    S_READING     = 5'h0b,
    S_READING_AP  = 5'h0c,
    S_REFRESHING  = 5'h0d,
    S_WRITING     = 5'h12,
    S_WRITING_AP  = 5'h13
  } bank_state_e;

  bank_state_e   state_q [NBANKS];
  bank_state_e   state_d [NBANKS];
  logic [CW-1:0] cnt_q   [NBANKS];
  logic [CW-1:0] cnt_d   [NBANKS];
  logic [CW-1:0] tras_q  [NBANKS];
  logic [CW-1:0] tras_d  [NBANKS];
  logic          cmd_err_q, cmd_err_d;
  logic [7:0]    cmd;
  logic          multi;
  logic          all_idle;
  logic [AW-1:0] sel;

  // Bank index; bg is dropped entirely for single-group parts.
  generate
    if (BGWIDTH == 0) begin : g_nobg
      logic unused_bg;
      assign unused_bg = ^bg;
      assign sel       = ba;
    end else begin : g_bg
      assign sel = {bg, ba};
    end
  endgenerate

  assign cmd   = {ACT, PR, PRA, RD, RDA, WR, WRA, REF};
  assign multi = |(cmd & 8'(cmd - 8'd1));

  // Row open for column commands and precharge.
  function automatic logic is_open(input bank_state_e s);
    return (s == S_ACTIVE) || (s == S_READING) || (s == S_WRITING);
  endfunction

  // State, timing counters and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANKS; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
        tras_q[b]  <= '0;
      end
      cmd_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        tras_q[b]  <= tras_d[b];
      end
      cmd_err_q <= cmd_err_d;
    end
  end

  // Next state: every bank's timer advances, then the command overrides the addressed bank(s).
  always_comb begin
    cmd_err_d = 1'b0;
    all_idle  = 1'b1;
    for (int b = 0; b < NBANKS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      tras_d[b]  = (tras_q[b] != '0) ? CW'(tras_q[b] - CW'(1)) : '0;
      if (state_q[b] != S_IDLE) all_idle = 1'b0;
      case (state_q[b])
        S_ACTIVATING, S_READING, S_WRITING: begin
          if (cnt_q[b] == '0) state_d[b] = S_ACTIVE;
          else                cnt_d[b]   = CW'(cnt_q[b] - CW'(1));
        end
        S_READING_AP, S_WRITING_AP: begin
          if (cnt_q[b] == '0) begin
            state_d[b] = S_PRECHARGING;
            cnt_d[b]   = CW'(T_RP - 1);
          end else begin
            cnt_d[b] = CW'(cnt_q[b] - CW'(1));
          end
        end
        S_PRECHARGING, S_REFRESHING: begin
          if (cnt_q[b] == '0) state_d[b] = S_IDLE;
          else                cnt_d[b]   = CW'(cnt_q[b] - CW'(1));
        end
        default: ;
      endcase
    end

    if (multi) begin
      cmd_err_d = 1'b1;
    end else begin
      case (cmd)
        C_ACT: begin
          if (state_q[sel] == S_IDLE) begin
            state_d[sel] = S_ACTIVATING;
            cnt_d[sel]   = CW'(T_RCD - 1);
            tras_d[sel]  = CW'(T_RAS - 1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        C_RD, C_RDA, C_WR, C_WRA: begin
          if (is_open(state_q[sel])) begin
            case (cmd)
              C_RD:    begin state_d[sel] = S_READING;    cnt_d[sel] = CW'(D_RD - 1); end
              C_RDA:   begin state_d[sel] = S_READING_AP; cnt_d[sel] = CW'(D_RD - 1); end
              C_WR:    begin state_d[sel] = S_WRITING;    cnt_d[sel] = CW'(D_WR - 1); end
              default: begin state_d[sel] = S_WRITING_AP; cnt_d[sel] = CW'(D_WR - 1); end
            endcase
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        C_PR: begin
          // PR to an idle bank is a silent no-op.
          if (is_open(state_q[sel]) && (tras_q[sel] == '0)) begin
            state_d[sel] = S_PRECHARGING;
            cnt_d[sel]   = CW'(T_RP - 1);
          end else if (state_q[sel] != S_IDLE) begin
            cmd_err_d = 1'b1;
          end
        end
        C_PRA: begin
          for (int b = 0; b < NBANKS; b++) begin
            if (is_open(state_q[b])) begin
              if (tras_q[b] == '0) begin
                state_d[b] = S_PRECHARGING;
                cnt_d[b]   = CW'(T_RP - 1);
              end else begin
                cmd_err_d = 1'b1;
              end
            end
          end
        end
        C_REF: begin
          if (all_idle) begin
            for (int b = 0; b < NBANKS; b++) begin
              state_d[b] = S_REFRESHING;
              cnt_d[b]   = CW'(T_RFC - 1);
            end
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State codes and busy flags taken straight from the state register.
  always_comb begin
    BankFSM = '0;
    busy    = '0;
    for (int n = 0; n < NBANKS; n++) begin
      BankFSM[5*n +: 5] = state_q[n];
      busy[n]           = (state_q[n] != S_IDLE) && (state_q[n] != S_ACTIVE);
    end
  end

  assign cmd_err = cmd_err_q;

endmodule
